// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    localparam logic [31:0] BP_CNT_MAX = '1;

    function automatic logic [31:0] bp_sat_inc(input logic [31:0] v);
        return (v == BP_CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state: moves toward taken or not-taken, holding at the ends.
module bp_sat_ctr
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    bp_ctr_e cur;
    assign cur = bp_ctr_e'(ctr_i);

    always_comb begin
        ctr_o = ctr_i;
        case (cur)
            BP_SNT: ctr_o = taken_i ? BP_WNT : BP_SNT;
            BP_WNT: ctr_o = taken_i ? BP_WT  : BP_SNT;
            BP_WT:  ctr_o = taken_i ? BP_ST  : BP_WNT;
            BP_ST:  ctr_o = taken_i ? BP_ST  : BP_WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch prediction,
// decode-stage training, mispredict/redirect generation and statistics counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken_f,
    output logic [31:0] pred_target_f,
    input  logic        upd_valid_d,
    input  logic        stall_d,
    input  logic [31:0] upd_pc_d,
    input  logic        upd_taken_d,
    input  logic [31:0] upd_target_d,
    input  logic        pred_taken_d,
    input  logic [31:0] pred_target_d,
    output logic        mispredict_d,
    output logic [31:0] redirect_pc_d,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        br_count_q, br_count_d;
    logic [31:0]        mp_count_q, mp_count_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, upd, write_hit, alloc;
    logic [1:0]       ctr_next;

    // Fetch lookup reads the arrays directly, so a same-cycle write is not yet visible.
    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken_f  = f_hit && ctr_q[f_idx][1];
    assign pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + 32'd4;

    assign upd       = upd_valid_d && !stall_d;
    assign u_idx     = upd_pc_d[IDX_W+1:2];
    assign u_tag     = upd_pc_d[IDX_W+TAG_W+1:IDX_W+2];
    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign write_hit = upd && u_hit;
    assign alloc     = upd && !u_hit && upd_taken_d;

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (upd_taken_d),
        .ctr_o   (ctr_next)
    );

    assign mispredict_d  = upd && ((pred_taken_d != upd_taken_d) ||
                                   (upd_taken_d && (pred_target_d != upd_target_d)));
    assign redirect_pc_d = upd_taken_d ? upd_target_d : upd_pc_d + 32'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BP_WNT;
            end
        end else if (alloc) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= BP_WT;
        end else if (write_hit) begin
            ctr_q[u_idx]   <= ctr_next;
        end
    end

    // Tag and target hold no reset; stale contents are masked by the cleared valid bits.
    always_ff @(posedge clk) begin
        if (!rst && (alloc || (write_hit && upd_taken_d))) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target_d;
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd)          br_count_d = bp_sat_inc(br_count_q);
        if (mispredict_d) mp_count_d = bp_sat_inc(mp_count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule
